// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state encoding and address-field widths for the data cache
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        RESUME    = 2'd3
    } state_t;

    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 3;

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int num_lines);
        return addr_w - OFFSET_W - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - valid/dirty/tag/data arrays: one comb read port, line write, word write
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256,
    parameter int INDEX_W   = 5,
    parameter int TAG_W     = 22
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_W-1:0]    rd_index,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_BITS-1:0]  rd_data,
    input  logic                  line_we,
    input  logic [INDEX_W-1:0]    line_index,
    input  logic [TAG_W-1:0]      line_tag,
    input  logic [LINE_BITS-1:0]  line_data,
    input  logic                  word_we,
    input  logic [INDEX_W-1:0]    word_index,
    input  logic [WORD_SEL_W-1:0] word_sel,
    input  logic [31:0]           word_data
);

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_BITS-1:0] data_mem [NUM_LINES];

    assign rd_valid = valid[rd_index];
    assign rd_dirty = dirty[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

    // Only the status bits are reset; tag and data are qualified by valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (line_we) begin
                valid[line_index] <= 1'b1;
                dirty[line_index] <= 1'b0;
            end
            if (word_we) begin
                dirty[word_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_mem[line_index]  <= line_tag;
            data_mem[line_index] <= line_data;
        end
        if (word_we) begin
            data_mem[word_index][{word_sel, 5'b0} +: 32] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back cache controller; DCACHE_STATS_EN adds hit/miss counters
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_W-1:0]    p1_addr_i,
    input  logic [31:0]          p1_data_i,
    input  logic                 p1_mem_read_i,
    input  logic                 p1_mem_write_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
`endif
);

    localparam int INDEX_W = index_w(NUM_LINES);
    localparam int TAG_W   = tag_w(ADDR_W, NUM_LINES);

    state_t state, next_state;

    logic [TAG_W-1:0]      lat_tag;
    logic [INDEX_W-1:0]    lat_index;
    logic [TAG_W-1:0]      addr_tag;
    logic [INDEX_W-1:0]    addr_index;
    logic [WORD_SEL_W-1:0] word_sel;
    logic [INDEX_W-1:0]    rd_index;
    logic                  rd_valid, rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [LINE_BITS-1:0]  rd_data;
    logic                  req, hit, line_we, word_we;
    logic                  unused_addr_bits;

    assign addr_tag         = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign addr_index       = p1_addr_i[OFFSET_W +: INDEX_W];
    assign word_sel         = p1_addr_i[2 +: WORD_SEL_W];
    assign unused_addr_bits = ^p1_addr_i[1:0];
    assign req              = p1_mem_read_i | p1_mem_write_i;

    // During a miss the arrays are looked up with the latched index so the victim stays put.
    assign rd_index = (state == IDLE) ? addr_index : lat_index;
    assign hit      = (state == IDLE) && req && rd_valid && (rd_tag == addr_tag);

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .LINE_BITS (LINE_BITS),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W)
    ) u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_index   (rd_index),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .line_we    (line_we),
        .line_index (lat_index),
        .line_tag   (lat_tag),
        .line_data  (mem_data_i),
        .word_we    (word_we),
        .word_index (addr_index),
        .word_sel   (word_sel),
        .word_data  (p1_data_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            lat_tag   <= '0;
            lat_index <= '0;
        end else begin
            state <= next_state;
            if ((state == IDLE) && req && !hit) begin
                lat_tag   <= addr_tag;
                lat_index <= addr_index;
            end
        end
    end

    always_comb begin
        next_state   = state;
        p1_stall_o   = 1'b0;
        p1_data_o    = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        line_we      = 1'b0;
        word_we      = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    p1_data_o = rd_data[{word_sel, 5'b0} +: 32];
                    word_we   = p1_mem_write_i;
                end else if (req) begin
                    p1_stall_o = 1'b1;
                    next_state = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {rd_tag, lat_index, {OFFSET_W{1'b0}}};
                mem_data_o   = rd_data;
                if (mem_ack_i) next_state = ALLOCATE;
            end
            ALLOCATE: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {lat_tag, lat_index, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    line_we    = 1'b1;
                    next_state = RESUME;
                end
            end
            RESUME: begin
                p1_stall_o = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic after_resume;

    // The replayed access after a refill is part of the miss, not a new hit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_o    <= '0;
            miss_cnt_o   <= '0;
            after_resume <= 1'b0;
        end else begin
            after_resume <= (state == RESUME);
            if (hit && !after_resume) hit_cnt_o <= hit_cnt_o + 32'd1;
            if ((state == IDLE) && req && !hit) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule
